// File: rtl/enigma_step_ctrl.sv
// Sequencer in front of the 4-stage enigma pipeline: steps the rotors per
// accepted letter, issues letters into the pipeline, tracks them through it
// and buffers the results in a first-word fall-through FIFO.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | accepting letters, stepping rotors
// ST_DRAIN | new start positions latched, waiting for the pipeline to empty
// ST_LOAD  | one cycle: apply latched positions or flag a bad load
module enigma_step_ctrl #(
  parameter int PIPE_LAT   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int NOTCH1     = 16,
  parameter int NOTCH2     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_load,
  input  logic [4:0]  cfg_pos1,
  input  logic [4:0]  cfg_pos2,
  input  logic [4:0]  cfg_pos3,
  output logic        cfg_ack,
  output logic        cfg_err,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [25:0] in_letter,
  output logic [25:0] enc_letter,
  output logic [4:0]  enc_n1,
  output logic [4:0]  enc_n2,
  output logic [4:0]  enc_n3,
  input  logic [25:0] enc_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [25:0] out_letter,
  output logic        err_onehot,
  output logic [4:0]  pos1,
  output logic [4:0]  pos2,
  output logic [4:0]  pos3
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]    N1      = 5'(NOTCH1);
  localparam logic [4:0]    N2      = 5'(NOTCH2);
  localparam logic [CW:0]   CREDITS = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOAD} state_t;

  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  state_t state_q, state_d;
  logic [4:0]  pos1_q, pos1_d, pos2_q, pos2_d, pos3_q, pos3_d;
  logic [4:0]  lat1_q, lat1_d, lat2_q, lat2_d, lat3_q, lat3_d;
  logic        cfg_err_q, cfg_err_d, err_onehot_q, err_onehot_d;
  logic [25:0] enc_letter_q, enc_letter_d;
  logic [4:0]  enc_n1_q, enc_n1_d, enc_n2_q, enc_n2_d, enc_n3_q, enc_n3_d;
  logic                issue_v_q, issue_v_d;
  logic [PIPE_LAT-1:0] tag_q, tag_d;
  logic [CW-1:0] inflight_q, inflight_d, fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [25:0]   mem_q [FIFO_DEPTH];
  logic [25:0]   mem_d [FIFO_DEPTH];

  logic [CW:0] credit_sum;
  logic        accept, mid, carry2, letter_ok;
  logic [4:0]  nxt1, nxt2, nxt3;
  logic        push, pop, wr_en, fifo_full;

  // Handshake, credit accounting and the rotor stepping rule on pre-step positions
  always_comb begin
    credit_sum = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    in_ready   = (state_q == ST_RUN) && !cfg_load && (credit_sum < CREDITS);
    accept     = in_valid && in_ready;
    mid        = (pos2_q == N2);
    carry2     = (pos1_q == N1) || mid;
    nxt1       = inc26(pos1_q);
    nxt2       = carry2 ? inc26(pos2_q) : pos2_q;
    nxt3       = mid ? inc26(pos3_q) : pos3_q;
    letter_ok  = (in_letter != 26'd0) && ((in_letter & (in_letter - 26'd1)) == 26'd0);
  end

  // Sequencer: run / drain the pipeline / apply new start positions
  always_comb begin
    state_d   = state_q;
    pos1_d    = pos1_q;
    pos2_d    = pos2_q;
    pos3_d    = pos3_q;
    lat1_d    = lat1_q;
    lat2_d    = lat2_q;
    lat3_d    = lat3_q;
    cfg_err_d = cfg_err_q;
    cfg_ack   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (cfg_load) begin
          lat1_d  = cfg_pos1;
          lat2_d  = cfg_pos2;
          lat3_d  = cfg_pos3;
          state_d = ST_DRAIN;
        end else if (accept) begin
          pos1_d = nxt1;
          pos2_d = nxt2;
          pos3_d = nxt3;
        end
      end
      ST_DRAIN: begin
        if (inflight_q == '0) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if ((lat1_q <= 5'd25) && (lat2_q <= 5'd25) && (lat3_q <= 5'd25)) begin
          pos1_d  = lat1_q;
          pos2_d  = lat2_q;
          pos3_d  = lat3_q;
          cfg_ack = 1'b1;
        end else begin
          cfg_err_d = 1'b1;
        end
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Issue into the pipeline and follow each letter with a valid tag
  always_comb begin
    enc_letter_d = accept ? in_letter : 26'd0;
    enc_n1_d     = accept ? nxt1 : enc_n1_q;
    enc_n2_d     = accept ? nxt2 : enc_n2_q;
    enc_n3_d     = accept ? nxt3 : enc_n3_q;
    err_onehot_d = err_onehot_q || (accept && !letter_ok);
    issue_v_d    = accept;
    tag_d        = PIPE_LAT'({tag_q, issue_v_q});
    push         = tag_q[PIPE_LAT-1];
    inflight_d   = inflight_q + CW'(accept) - CW'(push);
  end

  // Output FIFO, first-word fall-through
  always_comb begin
    fifo_full  = (fifo_cnt_q == FULL);
    out_valid  = (fifo_cnt_q != '0);
    out_letter = mem_q[rd_ptr_q];
    pop        = out_valid && out_ready;
    wr_en      = push && (!fifo_full || pop);
    fifo_cnt_d = fifo_cnt_q + CW'(wr_en) - CW'(pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1);
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = enc_result;
  end

  // Control and datapath registers; reset drops everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pos1_q       <= '0;
      pos2_q       <= '0;
      pos3_q       <= '0;
      lat1_q       <= '0;
      lat2_q       <= '0;
      lat3_q       <= '0;
      cfg_err_q    <= 1'b0;
      err_onehot_q <= 1'b0;
      enc_letter_q <= '0;
      enc_n1_q     <= '0;
      enc_n2_q     <= '0;
      enc_n3_q     <= '0;
      issue_v_q    <= 1'b0;
      tag_q        <= '0;
      inflight_q   <= '0;
      fifo_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      pos1_q       <= pos1_d;
      pos2_q       <= pos2_d;
      pos3_q       <= pos3_d;
      lat1_q       <= lat1_d;
      lat2_q       <= lat2_d;
      lat3_q       <= lat3_d;
      cfg_err_q    <= cfg_err_d;
      err_onehot_q <= err_onehot_d;
      enc_letter_q <= enc_letter_d;
      enc_n1_q     <= enc_n1_d;
      enc_n2_q     <= enc_n2_d;
      enc_n3_q     <= enc_n3_d;
      issue_v_q    <= issue_v_d;
      tag_q        <= tag_d;
      inflight_q   <= inflight_d;
      fifo_cnt_q   <= fifo_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // FIFO storage needs no reset; the count qualifies every entry
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // The credit rule should make a write into a full FIFO impossible
  assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop))
    else $error("enigma_step_ctrl: result written while FIFO full");

  assign cfg_err    = cfg_err_q;
  assign err_onehot = err_onehot_q;
  assign enc_letter = enc_letter_q;
  assign enc_n1     = enc_n1_q;
  assign enc_n2     = enc_n2_q;
  assign enc_n3     = enc_n3_q;
  assign pos1       = pos1_q;
  assign pos2       = pos2_q;
  assign pos3       = pos3_q;

endmodule

// File: doc/enigma_step_ctrl.md
Name: enigma_step_ctrl

Overview:
- Sequencer placed in front of the 4-stage enigma encryption pipeline.
- Accepts plaintext letters over a valid/ready handshake and steps the three rotor positions per letter, with odometer stepping plus the middle-rotor double-step.
- Drives the pipeline's letter and rotor-position inputs, tracks letters in flight, and buffers results in an output FIFO so the non-stallable pipeline never loses data.
- Also sequences safe reloading of rotor start positions.

Parameters:
- PIPE_LAT, 4: clock edges from enc_letter/enc_n* registered to enc_result valid.
- FIFO_DEPTH, 8: output FIFO entries; must be >= PIPE_LAT+1.
- NOTCH1, 16: rotor-1 position at which rotor 2 is carried.
- NOTCH2, 4: rotor-2 position at which rotors 2 and 3 are carried (double step).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Single clock, asynchronous, active-high.
- cfg_load  in  1  pulse: request new start positions.
- cfg_pos1, cfg_pos2, cfg_pos3  in  5 each  start positions, 0..25.
- cfg_ack  out  1  one-cycle pulse when new positions are applied.
- cfg_err  out  1  sticky: a cfg_load carried a position >25.
- in_valid  in  1  plaintext valid.
- in_ready  out  1  controller can accept.
- in_letter  in  26  one-hot plaintext.
- enc_letter  out  26  to pipeline input_letter.
- enc_n1, enc_n2, enc_n3  out  5 each  to pipeline rotor positions.
- enc_result  in  26  from pipeline output_letter.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  downstream accepts.
- out_letter  out  26  one-hot ciphertext.
- err_onehot  out  1  sticky: an accepted in_letter was not one-hot.
- pos1, pos2, pos3  out  5 each  current committed positions.

Behaviour:
Reset:
- State RUN; pos* = 0; enc_* = 0; FIFO empty; in-flight count = 0.
- out_valid = 0; cfg_ack = cfg_err = err_onehot = 0.
- in_ready = 1 from the first cycle after reset deasserts.
- Reset mid-operation discards in-flight letters and FIFO contents.

Stepping (evaluated on accept, i.e. in_valid & in_ready):
- mid = (pos2==NOTCH2).
- pos1 += 1.
- pos2 += 1 if (pos1==NOTCH1) or mid.
- pos3 += 1 if mid.
- All tests use pre-step values; all increments are mod 26 (25 -> 0).
- Letters are encrypted with the post-step positions.

Issue:
- On the accept edge, register enc_letter = in_letter and enc_n* = the new pos*.
- On any cycle without accept, drive enc_letter = 0; enc_n* hold their values (bubble).
- A non-one-hot letter (zero or multi-bit) is still accepted and issued unchanged, and sets err_onehot.

Tracking:
- A PIPE_LAT-deep valid shift register follows each issue.
- When the tag emerges, write enc_result to the FIFO on the next edge.
- Latency from accept edge to out_valid (FIFO empty) = PIPE_LAT+1 = 5 cycles.

Credit rule:
- in_ready = (state==RUN) && !cfg_load && (inflight + fifo_count) < FIFO_DEPTH.
- A same-cycle FIFO pop is not credited.
- The FIFO can never overflow; an assertion fires on a write while full.

Output:
- Standard FIFO semantics, first-word fall-through.
- out_letter is stable while out_valid & !out_ready.
- Letter order is preserved.
- Simultaneous push and pop while full or empty is handled correctly.

FSM:
- RUN -> DRAIN on cfg_load.
  - cfg_pos* are latched; a cfg_load arriving outside RUN is ignored.
- DRAIN: in_ready = 0; when inflight == 0, go to LOAD.
  - The FIFO need not be empty.
- LOAD, one cycle:
  - If every latched position <= 25: pos* = latched values and cfg_ack = 1.
  - Otherwise: set cfg_err and leave pos* unchanged.
  - Then return to RUN.

Test Plan:
1. Reset, load (0,0,0), send letter bit0 -> enc_n1=1, enc_n2=0, enc_n3=0 the cycle after accept; out_valid exactly 5 cycles after accept, out_letter = enc_result.
2. Load pos1=15, pos2=3, pos3=0; send 3 letters -> positions used: (16,3,0), (17,4,0), (18,5,1), confirming the double step.
3. Load pos1=25, pos2=25, pos3=25 with NOTCH1=25 and NOTCH2=25; send 1 letter -> (0,0,0) wrap on all rotors.
4. out_ready=0, offer 12 letters back-to-back -> exactly 8 accepted, in_ready low after that; raise out_ready -> 8 results in issue order, one per cycle, then accepting resumes.
5. cfg_load with 3 letters in flight -> in_ready low immediately; the 3 results still arrive; cfg_ack pulses one cycle after inflight reaches 0; the next letter uses the new positions +1 step. cfg_pos2=30 -> cfg_err=1, positions unchanged.
6. Send in_letter=26'h3 -> err_onehot=1 stays set; assert rst with 2 letters in flight -> out_valid=0, pos*=0, nothing emitted afterwards.
